// File: rtl/bus_ram_responder.sv
// Word-organised RAM slave on a simple request/ready data bus.
// Ports: clk, res (sync, active-high), db_addr/db_accessType/db_memLen/db_wdata
// in; db_rdata/db_ready/db_fault out (valid only during the ready pulse).
module bus_ram_responder #(
   parameter int          ADDR_BITS   = 12,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
   input  logic        clk,
   input  logic        res,
   input  logic [31:0] db_addr,
   input  logic [1:0]  db_accessType,
   input  logic [1:0]  db_memLen,
   input  logic [31:0] db_wdata,
   output logic [31:0] db_rdata,
   output logic        db_ready,
   output logic        db_fault
);

   localparam int DEPTH = 1 << ADDR_BITS;
   // one past the last valid byte, kept 33 bits wide so it cannot wrap
   localparam logic [32:0] TOP = {1'b0, BASE_ADDR} + (33'd4 << ADDR_BITS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [1:0]             lane_q, lane_d;
   logic [1:0]             len_q, len_d;
   logic                   wr_q, wr_d;
   logic                   fault_q, fault_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rdata_q, rdata_d;

   logic [31:0] mem [DEPTH];

   logic [ADDR_BITS-1:0] in_idx;
   logic                 in_fault;
   logic                 enter;
   logic                 wr_en;
   logic [3:0]           be;
   logic [31:0]          cur_word, wsh, rsh, wr_word, rd_word;

   always_comb begin
      in_idx   = ADDR_BITS'((db_addr - BASE_ADDR) >> 2);
      in_fault = (db_memLen == 2'd3)
               | ((db_memLen == 2'd1) & db_addr[0])
               | ((db_memLen == 2'd2) & (db_addr[1:0] != 2'd0))
               | (db_addr < BASE_ADDR)
               | ({1'b0, db_addr} >= TOP);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      len_d   = len_q;
      wr_d    = wr_q;
      fault_d = fault_q;
      wdata_d = wdata_q;
      rdata_d = '0;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (db_accessType != 2'd0) begin
               idx_d   = in_idx;
               lane_d  = db_addr[1:0];
               len_d   = db_memLen;
               wr_d    = (db_accessType == 2'd2);
               fault_d = in_fault;
               wdata_d = db_wdata;
               if (WS == 4'd0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WS;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // the decrement that reaches zero is the last wait cycle
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // the RAM access happens on the edge into RESP, using the _d
      // values so a zero-wait accept works on still-unlatched inputs
      enter    = (state_d == RESP) && (state_q != RESP);
      cur_word = mem[idx_d];
      case (len_d)
         2'd0:    be = 4'b0001 << lane_d;
         2'd1:    be = 4'b0011 << lane_d;
         default: be = 4'b1111;
      endcase
      wsh = wdata_d << {lane_d, 3'b000};
      rsh = cur_word >> {lane_d, 3'b000};
      for (int k = 0; k < 4; k++) begin
         wr_word[8*k +: 8] = be[k] ? wsh[8*k +: 8] : cur_word[8*k +: 8];
      end
      case (len_d)
         2'd0:    rd_word = {24'h0, rsh[7:0]};
         2'd1:    rd_word = {16'h0, rsh[15:0]};
         default: rd_word = rsh;
      endcase
      if (enter && !fault_d) begin
         if (wr_d) wr_en   = 1'b1;
         else      rdata_d = rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         fault_q <= fault_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset; reset only blocks the write
   always_ff @(posedge clk) begin
      if (!res && wr_en) mem[idx_d] <= wr_word;
   end

   assign db_ready = (state_q == RESP);
   assign db_fault = db_ready & fault_q;
   assign db_rdata = rdata_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: a 2-wait-state and a 0-wait-state instance
// share address/data inputs; each has its own access-type strobe.
module tb_bus_ram_responder;

   localparam logic [1:0] T_R = 2'd1, T_W = 2'd2, T_X = 2'd3;
   localparam logic [1:0] L_B = 2'd0, L_H = 2'd1, L_W = 2'd2, L_BAD = 2'd3;

   typedef struct {
      bit          fast;
      logic [1:0]  t;
      logic [1:0]  l;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        ef;
   } stim_t;

   typedef struct {
      logic [31:0] rd;
      logic        f;
      int          lat;
      int          rc;
   } res_t;

   logic        clk = 1'b0;
   logic        res;
   logic [31:0] addr, wdata;
   logic [1:0]  len, type0, type2;
   logic [31:0] rd0, rd2;
   logic        rdy0, rdy2, flt0, flt2;

   res_t sbq[$];
   res_t obq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bus_ram_responder #(.WAIT_STATES(2)) u_dut2 (
      .clk(clk), .res(res), .db_addr(addr), .db_accessType(type2),
      .db_memLen(len), .db_wdata(wdata), .db_rdata(rd2),
      .db_ready(rdy2), .db_fault(flt2)
   );

   bus_ram_responder #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .res(res), .db_addr(addr), .db_accessType(type0),
      .db_memLen(len), .db_wdata(wdata), .db_rdata(rd0),
      .db_ready(rdy0), .db_fault(flt0)
   );

   // present one request in an IDLE cycle, drop the strobe after the
   // accept edge, and wait (bounded) for the ready pulse
   task automatic issue(input stim_t s, output res_t o);
      @(negedge clk);
      addr = s.a; len = s.l; wdata = s.wd;
      if (s.fast) type0 = s.t; else type2 = s.t;
      o.lat = -1; o.rc = -1; o.rd = 'x; o.f = 1'bx;
      for (int n = 2; n < 24; n++) begin
         @(negedge clk);
         type0 = 2'd0; type2 = 2'd0;
         if (s.fast ? rdy0 : rdy2) begin
            o.lat = n; o.rc = cyc;
            o.rd  = s.fast ? rd0 : rd2;
            o.f   = s.fast ? flt0 : flt2;
            break;
         end
      end
   endtask

   task automatic run_tbl(input stim_t s[$]);
      res_t o;
      foreach (s[i]) begin
         sbq.push_back('{s[i].erd, s[i].ef, s[i].fast ? 2 : 4, 0});
         issue(s[i], o);
         obq.push_back(o);
      end
   endtask

   task automatic test_reset();
      bit seen;
      @(negedge clk);
      checks += 4;
      if (rdy2 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", rdy2); end
      if (flt2 !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", flt2); end
      if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rd2); end
      if (rdy0 !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", rdy0); end
      // request coinciding with reset must not be accepted
      res = 1'b1; type2 = T_R; addr = 32'h80000010; len = L_W;
      @(negedge clk);
      res = 1'b0; type2 = 2'd0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rdy2) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL rst_priority got ready 1 exp 0"); end
   endtask

   task automatic test_seq(input string name, input stim_t s[$], input bit gap);
      res_t e, o;
      int prev = -1;
      run_tbl(s);
      for (int i = 0; sbq.size() > 0; i++) begin
         e = sbq.pop_front();
         o = obq.pop_front();
         checks++;
         if (o.rd !== e.rd || o.f !== e.f || o.lat !== e.lat) begin
            errors++;
            $display("FAIL %s[%0d] got rdata %h fault %b lat %0d exp rdata %h fault %b lat %0d",
                     name, i, o.rd, o.f, o.lat, e.rd, e.f, e.lat);
         end
         if (gap && prev >= 0) begin
            checks++;
            if (o.rc - prev !== 2) begin
               errors++;
               $display("FAIL %s[%0d]_spacing got %0d exp 2", name, i, o.rc - prev);
            end
         end
         prev = o.rc;
      end
   endtask

   task automatic test_word_rw();
      stim_t s[$];
      s.push_back('{1'b0, T_W, L_W, 32'h80000010, 32'hDEADBEEF, 32'h0, 1'b0});
      s.push_back('{1'b0, T_R, L_W, 32'h80000010, 32'h0, 32'hDEADBEEF, 1'b0});
      test_seq("word_rw", s, 1'b0);
   endtask

   task automatic test_lanes();
      stim_t s[$];
      s.push_back('{1'b0, T_W, L_B, 32'h80000011, 32'hFFFFFF5A, 32'h0, 1'b0});
      s.push_back('{1'b0, T_R, L_H, 32'h80000012, 32'h0, 32'h0000DEAD, 1'b0});
      s.push_back('{1'b0, T_R, L_W, 32'h80000010, 32'h0, 32'hDEAD5AEF, 1'b0});
      s.push_back('{1'b0, T_R, L_B, 32'h80000011, 32'h0, 32'h0000005A, 1'b0});
      s.push_back('{1'b0, T_X, L_B, 32'h80000013, 32'h0, 32'h000000DE, 1'b0});
      s.push_back('{1'b0, T_W, L_H, 32'h80000012, 32'hAAAA1234, 32'h0, 1'b0});
      s.push_back('{1'b0, T_R, L_W, 32'h80000010, 32'h0, 32'h12345AEF, 1'b0});
      test_seq("lanes", s, 1'b0);
   endtask

   task automatic test_fault();
      stim_t s[$];
      s.push_back('{1'b0, T_W, L_W, 32'h80000000, 32'h11111111, 32'h0, 1'b0});
      s.push_back('{1'b0, T_W, L_W, 32'h80003FFC, 32'h00000077, 32'h0, 1'b0});
      s.push_back('{1'b0, T_R, L_H, 32'h80000001, 32'h0, 32'h0, 1'b1});
      s.push_back('{1'b0, T_W, L_W, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'h0, 1'b1});
      s.push_back('{1'b0, T_R, L_BAD, 32'h80000010, 32'h0, 32'h0, 1'b1});
      s.push_back('{1'b0, T_W, L_BAD, 32'h80000010, 32'h0, 32'h0, 1'b1});
      s.push_back('{1'b0, T_W, L_W, 32'h80004000, 32'hBADBADBA, 32'h0, 1'b1});
      s.push_back('{1'b0, T_R, L_W, 32'h80004000, 32'h0, 32'h0, 1'b1});
      s.push_back('{1'b0, T_W, L_H, 32'h80000013, 32'hFFFFFFFF, 32'h0, 1'b1});
      s.push_back('{1'b0, T_W, L_W, 32'h80000012, 32'hFFFFFFFF, 32'h0, 1'b1});
      s.push_back('{1'b0, T_R, L_W, 32'h80000010, 32'h0, 32'h12345AEF, 1'b0});
      s.push_back('{1'b0, T_R, L_W, 32'h80000000, 32'h0, 32'h11111111, 1'b0});
      s.push_back('{1'b0, T_R, L_W, 32'h80003FFC, 32'h0, 32'h00000077, 1'b0});
      test_seq("fault", s, 1'b0);
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      s.push_back('{1'b1, T_W, L_W, 32'h80000000, 32'hA5A5A5A5, 32'h0, 1'b0});
      s.push_back('{1'b1, T_W, L_W, 32'h80000004, 32'h0F0F0F0F, 32'h0, 1'b0});
      s.push_back('{1'b1, T_X, L_W, 32'h80000000, 32'h0, 32'hA5A5A5A5, 1'b0});
      s.push_back('{1'b1, T_X, L_W, 32'h80000004, 32'h0, 32'h0F0F0F0F, 1'b0});
      s.push_back('{1'b1, T_R, L_H, 32'h80000003, 32'h0, 32'h0, 1'b1});
      test_seq("b2b", s, 1'b1);
   endtask

   task automatic test_reset_mid_write();
      stim_t s[$];
      bit seen;
      s.push_back('{1'b0, T_W, L_W, 32'h80000020, 32'hCAFEF00D, 32'h0, 1'b0});
      test_seq("pre_write", s, 1'b0);
      @(negedge clk);
      addr = 32'h80000020; len = L_W; wdata = 32'h12345678; type2 = T_W;
      @(negedge clk);
      type2 = 2'd0; res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rdy2) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ready got 1 exp 0"); end
      s.delete();
      s.push_back('{1'b0, T_R, L_W, 32'h80000020, 32'h0, 32'hCAFEF00D, 1'b0});
      test_seq("midrst_read", s, 1'b0);
   endtask

   task automatic test_withdrawn();
      stim_t s[$];
      int pulses;
      // issue() drops the strobe right after the accept edge
      s.push_back('{1'b0, T_R, L_H, 32'h80000022, 32'h0, 32'h0000CAFE, 1'b0});
      test_seq("withdrawn", s, 1'b0);
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (rdy2) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL withdrawn_extra got %0d exp 0", pulses); end
   endtask

   initial begin
      res = 1'b1; type0 = 2'd0; type2 = 2'd0;
      addr = '0; len = '0; wdata = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_word_rw();
      test_lanes();
      test_fault();
      test_back_to_back();
      test_reset_mid_write();
      test_withdrawn();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
